// File: rtl/dmem_lsu.sv
// dmem_lsu: four byte-wide RAM banks with RV32I load/store lane alignment and a valid/ready front end.
// Define DMEM_OUT_REG_EN to register the response (latency 2, one request per 3 cycles).
module dmem_lsu #(
  parameter int ADDR_WIDTH = 12,
  parameter bit INIT_ZERO  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);
  localparam logic [1:0] S_IDLE = 2'd0, S_ACCESS = 2'd1;
`ifdef DMEM_OUT_REG_EN
  localparam logic [1:0] S_RESP = 2'd2, S_AFTER = S_RESP;
`else
  localparam logic [1:0] S_AFTER = S_IDLE;
`endif
  logic [7:0]            r_mem [4][2**ADDR_WIDTH];
  logic [1:0]            r_state, w_next, w_sz, r_a;
  logic                  r_ready, r_we, r_err, w_fire, w_err, w_acc;
  logic [2:0]            r_f3;
  logic [ADDR_WIDTH-1:0] r_word, w_widx;
  logic [3:0]            w_mask;
  logic [31:0]           w_lane, w_word, w_ext, w_rdata;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  if (INIT_ZERO) begin : g_init
    initial for (int i = 0; i < 4; i++) for (int j = 0; j < 2**ADDR_WIDTH; j++) r_mem[i][j] = 8'h00;
  end
  assign w_sz      = req_funct3[1:0];
  assign w_err     = (w_sz == 2'd3) || (req_funct3[2] && (req_we || req_funct3[1])) ||
                     (w_sz == 2'd1 && req_addr[0]) || (w_sz == 2'd2 && req_addr[1:0] != 2'd0);
  assign w_mask    = w_err ? 4'b0000 : w_sz == 2'd0 ? 4'b0001 << req_addr[1:0] :
                     w_sz == 2'd1 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_lane    = w_sz == 2'd0 ? {4{req_wdata[7:0]}} : w_sz == 2'd1 ? {2{req_wdata[15:0]}} : req_wdata;
  assign w_widx    = req_addr[ADDR_WIDTH+1:2];
  assign req_ready = r_ready && !rst;
  assign w_fire    = req_valid && req_ready;
  assign w_next    = r_state == S_IDLE ? (w_fire ? S_ACCESS : S_IDLE) : r_state == S_ACCESS ? S_AFTER : S_IDLE;
  // Stores land on the accept edge; reads use the registered word index, so a following load sees them.
  always @(posedge clk)
    if (w_fire && req_we)
      for (int i = 0; i < 4; i++)
        if (w_mask[i]) r_mem[i][w_widx] <= w_lane[8*i +: 8];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= w_next == S_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (w_fire) begin
      r_we   <= req_we;
      r_f3   <= req_funct3;
      r_a    <= req_addr[1:0];
      r_word <= w_widx;
      r_err  <= w_err;
    end
  end
  assign w_word  = {r_mem[3][r_word], r_mem[2][r_word], r_mem[1][r_word], r_mem[0][r_word]};
  assign w_byte  = w_word[{r_a, 3'b000} +: 8];
  assign w_half  = r_a[1] ? w_word[31:16] : w_word[15:0];
  assign w_ext   = r_f3[1:0] == 2'd0 ? {{24{w_byte[7] & ~r_f3[2]}}, w_byte} :
                   r_f3[1:0] == 2'd1 ? {{16{w_half[15] & ~r_f3[2]}}, w_half} : w_word;
  assign w_rdata = (r_we || r_err) ? 32'h0 : w_ext;
  assign w_acc   = r_state == S_ACCESS && !rst;
`ifdef DMEM_OUT_REG_EN
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_rdata <= w_acc ? w_rdata : 32'h0;
      r_rsp_err   <= w_acc && r_err;
    end
  end
  assign rsp_valid = r_state == S_RESP && !rst;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
`else
  assign rsp_valid = w_acc;
  assign rsp_rdata = w_acc ? w_rdata : 32'h0;
  assign rsp_err   = w_acc && r_err;
`endif
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed load/store vectors with a response scoreboard for dmem_lsu.
module tb_dmem_lsu;
  localparam int AW = 12;
`ifdef DMEM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic          clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'd0;
  logic [AW+1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          req_ready, rsp_valid, rsp_err;
  logic [31:0]   rsp_rdata;
  typedef struct {logic [31:0] d; logic e; int c;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0, cyc = 0, a1 = 0, a2 = 0;
  dmem_lsu #(.ADDR_WIDTH(AW), .INIT_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (q.size() == 0) chk("unexpected rsp_valid", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.d);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.e});
        chk("rsp cycle", cyc, e.c);
      end
    end
  end
  task automatic issue(input bit we, input logic [2:0] f, input logic [15:0] a, input logic [31:0] wd,
                       input logic [31:0] ed, input bit ee, output int acc);
    int n;
    req_we = we; req_funct3 = f; req_addr = a[AW+1:0]; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("req_ready wait", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    acc = cyc;
    q.push_back('{ed, ee, cyc + LAT - 1});
    req_valid = 1'b0;
  endtask
  task automatic st(input logic [2:0] f, input logic [15:0] a, input logic [31:0] wd, input bit ee);
    int acc;
    issue(1'b1, f, a, wd, 32'h0, ee, acc);
  endtask
  task automatic ld(input logic [2:0] f, input logic [15:0] a, input logic [31:0] ed, input bit ee);
    int acc;
    issue(1'b0, f, a, 32'h0, ed, ee, acc);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", {31'd0, req_ready}, 32'd0);
    chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset rsp_err", {31'd0, rsp_err}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("ready after reset", {31'd0, req_ready}, 32'd1);
    st(3'd2, 16'h0010, 32'hDEADBEEF, 1'b0);
    ld(3'd2, 16'h0010, 32'hDEADBEEF, 1'b0);
    st(3'd2, 16'h0010, 32'h11223344, 1'b0);
    st(3'd0, 16'h0013, 32'h000000A5, 1'b0);
    ld(3'd2, 16'h0010, 32'hA5223344, 1'b0);
    ld(3'd0, 16'h0013, 32'hFFFFFFA5, 1'b0);
    ld(3'd4, 16'h0013, 32'h000000A5, 1'b0);
    ld(3'd1, 16'h0012, 32'hFFFFA522, 1'b0);
    ld(3'd5, 16'h0012, 32'h0000A522, 1'b0);
    ld(3'd0, 16'h0010, 32'h00000044, 1'b0);
    ld(3'd1, 16'h0010, 32'h00003344, 1'b0);
    st(3'd1, 16'h0011, 32'h0000FFFF, 1'b1);
    ld(3'd2, 16'h0010, 32'hA5223344, 1'b0);
    ld(3'd2, 16'h0012, 32'h0, 1'b1);
    ld(3'd3, 16'h0010, 32'h0, 1'b1);
    ld(3'd6, 16'h0010, 32'h0, 1'b1);
    ld(3'd1, 16'h0013, 32'h0, 1'b1);
    st(3'd4, 16'h0010, 32'h0, 1'b1);
    ld(3'd2, 16'h0010, 32'hA5223344, 1'b0);
    st(3'd0, 16'h0011, 32'h00000080, 1'b0);
    ld(3'd0, 16'h0011, 32'hFFFFFF80, 1'b0);
    st(3'd1, 16'h0012, 32'h1234BEEF, 1'b0);
    ld(3'd2, 16'h0010, 32'hBEEF8044, 1'b0);
    ld(3'd5, 16'h0012, 32'h0000BEEF, 1'b0);
    ld(3'd1, 16'h0010, 32'hFFFF8044, 1'b0);
    st(3'd2, 16'h4000, 32'hCAFEF00D, 1'b0);
    ld(3'd2, 16'h0000, 32'hCAFEF00D, 1'b0);
    st(3'd2, 16'h3FFC, 32'h0BADC0DE, 1'b0);
    ld(3'd2, 16'h7FFC, 32'h0BADC0DE, 1'b0);
    issue(1'b1, 3'd2, 16'h0020, 32'h01020304, 32'h0, 1'b0, a1);
    issue(1'b0, 3'd2, 16'h0020, 32'h0, 32'h01020304, 1'b0, a2);
    chk("held request gap", a2 - a1, LAT + 1);
    req_we = 1'b0; req_funct3 = 3'd2; req_addr = 14'h0010; req_valid = 1'b1;
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 14'h0020; req_wdata = 32'hFFFFFFFF; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("abort rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("abort req_ready", {31'd0, req_ready}, 32'd1);
    chk("abort rsp_rdata", rsp_rdata, 32'd0);
    chk("abort rsp_err", {31'd0, rsp_err}, 32'd0);
    ld(3'd2, 16'h0020, 32'h01020304, 1'b0);
    repeat (6) @(posedge clk);
    chk("scoreboard drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
